// File: rtl/decoder_stream_pkg.sv
// decoder_stream_pkg: shared types and decode helper for the streaming 3-to-8 decoder
package decoder_stream_pkg;
   localparam int CODE_W = 3;
   localparam int OUT_W = 8;
   typedef struct packed {
      logic              en;
      logic [CODE_W-1:0] code;
   } dec_entry_t;
   function automatic logic [OUT_W-1:0] onehot_of(dec_entry_t e);
      return e.en ? OUT_W'(1) << e.code : '0;
   endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: generic synchronous FIFO, registered occupancy, head entry presented combinationally
module stream_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   // storage is not reset; occupancy alone decides which entries are live
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;
   // pointers wrap naturally at DEPTH (power of two); occupancy tracks full vs empty
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/decoder_3_8_stream.sv
// decoder_3_8_stream: buffered 3-to-8 decoder with handshakes, sticky output mask and code counter
module decoder_3_8_stream
   import decoder_stream_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_onehot,
   output logic [OUT_W-1:0]  acc_mask,
   input  logic              acc_clr,
   output logic [CNT_W-1:0]  code_cnt
);
   dec_entry_t wr_entry;
   dec_entry_t head;
   logic       full;
   logic       empty;
   logic       live;
   logic       push;
   logic       pop;
   assign wr_entry   = {in_en, in_code};
   assign in_ready   = live && !full;
   assign out_valid  = !empty;
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign out_onehot = out_valid ? onehot_of(head) : '0;
   stream_fifo #(.WIDTH($bits(dec_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .full  (full),
      .empty (empty),
      .rdata (head)
   );
   // in_ready stays low during reset and opens on the first edge after release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) live <= 1'b0;
      else live <= 1'b1;
   // sticky mask of transferred words; clear wins over a same-cycle transfer
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc_mask <= '0;
      else if (acc_clr) acc_mask <= '0;
      else if (pop) acc_mask <= acc_mask | out_onehot;
   // saturating count of accepted codes; clear wins over increment
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) code_cnt <= '0;
      else if (acc_clr) code_cnt <= '0;
      else if (push && code_cnt != '1) code_cnt <= code_cnt + 1'b1;
endmodule

// File: tb/tb_decoder_3_8_stream.sv
// tb_decoder_3_8_stream: directed and random stimulus against a queue-based reference model
module tb_decoder_3_8_stream;
   localparam int DEPTH = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_code = 3'd0;
   logic       in_en = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_onehot;
   logic [7:0] acc_mask;
   logic       acc_clr = 1'b0;
   logic [7:0] code_cnt;
   int         passed = 0;
   int         total = 0;
   logic [7:0] q[$];
   logic [7:0] m_acc = 8'h00;
   int         m_cnt = 0;
   bit         m_live = 1'b0;

   decoder_3_8_stream #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_en      (in_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .acc_mask   (acc_mask),
      .acc_clr    (acc_clr),
      .code_cnt   (code_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: a plain queue of expected output words
   always @(posedge clk or negedge rst_n) begin : model
      bit do_push;
      bit do_pop;
      logic [7:0] h;
      if (!rst_n) begin
         q.delete();
         m_acc = 8'h00;
         m_cnt = 0;
         m_live = 1'b0;
      end else begin
         do_push = in_valid && m_live && q.size() < DEPTH;
         do_pop = out_ready && q.size() > 0;
         h = q.size() > 0 ? q[0] : 8'h00;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(in_en ? 8'(2 ** int'(in_code)) : 8'h00);
         if (acc_clr) m_acc = 8'h00;
         else if (do_pop) m_acc = m_acc | h;
         if (acc_clr) m_cnt = 0;
         else if (do_push && m_cnt < 255) m_cnt = m_cnt + 1;
         m_live = 1'b1;
      end
   end

   // every cycle: all outputs against the model
   always @(negedge clk) begin
      chk("in_ready", in_ready, m_live && q.size() < DEPTH);
      chk("out_valid", out_valid, q.size() > 0);
      chk("out_onehot", out_onehot, q.size() > 0 ? q[0] : 8'h00);
      chk("acc_mask", acc_mask, m_acc);
      chk("code_cnt", code_cnt, m_cnt);
   end

   task automatic push_one(input logic [2:0] c, input logic e);
      in_valid = 1'b1;
      in_code = c;
      in_en = e;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic clear();
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      tick();
      chk("in_ready_after_rst", in_ready, 1);
      // single code 5
      out_ready = 1'b1;
      push_one(3'd5, 1'b1);
      chk("t1_valid", out_valid, 1);
      chk("t1_onehot", out_onehot, 8'h20);
      tick();
      chk("t1_acc", acc_mask, 8'h20);
      chk("t1_cnt", code_cnt, 1);
      // fill with downstream stalled
      out_ready = 1'b0;
      clear();
      for (int i = 0; i < 4; i++) push_one(3'(i), 1'b1);
      chk("full_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_code = 3'd4;
      in_en = 1'b1;
      repeat (2) tick();
      chk("held_cnt", code_cnt, 4);
      chk("held_in_ready", in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_word", out_onehot, 8'h01 << i);
         tick();
      end
      chk("drain_empty", out_valid, 0);
      chk("fill_acc", acc_mask, 8'h0F);
      // back-to-back stream 7..0
      clear();
      in_valid = 1'b1;
      in_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_code = 3'(7 - i);
         tick();
         chk("stream_valid", out_valid, 1);
         chk("stream_word", out_onehot, 8'h80 >> i);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_acc", acc_mask, 8'hFF);
      chk("stream_cnt", code_cnt, 8);
      // en=0 entry
      clear();
      push_one(3'd1, 1'b1);
      push_one(3'd6, 1'b0);
      chk("en0_valid", out_valid, 1);
      chk("en0_word", out_onehot, 8'h00);
      tick();
      chk("en0_acc", acc_mask, 8'h02);
      chk("en0_cnt", code_cnt, 2);
      // clear coincident with transfer of 8'h40
      out_ready = 1'b0;
      push_one(3'd6, 1'b1);
      chk("clr_word", out_onehot, 8'h40);
      out_ready = 1'b1;
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      out_ready = 1'b0;
      chk("clr_acc", acc_mask, 8'h00);
      chk("clr_cnt", code_cnt, 0);
      chk("clr_empty", out_valid, 0);
      // saturation
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 257; i++) begin
         in_code = 3'($urandom_range(0, 7));
         in_en = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("sat_cnt", code_cnt, 8'hFF);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_code = 3'($urandom_range(0, 7));
         in_en = ($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 1));
         acc_clr = ($urandom_range(0, 31) == 0);
         tick();
      end
      in_valid = 1'b0;
      acc_clr = 1'b0;
      // reset with three buffered entries
      out_ready = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 3; i++) push_one(3'(i + 2), 1'b1);
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_drop_valid", out_valid, 0);
      chk("rst_drop_word", out_onehot, 8'h00);
      chk("rst_drop_ready", in_ready, 0);
      chk("rst_drop_acc", acc_mask, 8'h00);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_valid", out_valid, 0);
      end
      chk("post_rst_acc", acc_mask, 8'h00);
      chk("post_rst_cnt", code_cnt, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
